// File: rtl/product_accumulator.sv
// Block-wise accumulator for an unstallable multiplier product stream.
// Completed block sums pass through a one-cycle stage into a one-entry output register.
module product_accumulator #(
    parameter int unsigned DATAWIDTH = 16,
    parameter int unsigned ACCWIDTH  = 40,
    parameter int unsigned LENWIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [2*DATAWIDTH-1:0] i_product,
    input  logic [LENWIDTH-1:0]    i_len,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [ACCWIDTH-1:0]    o_sum,
    output logic                   o_overflow,
    output logic                   o_drop
);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e                state_q, state_d;
    logic [ACCWIDTH-1:0]   acc_q, acc_d;
    logic [LENWIDTH-1:0]   cnt_q, cnt_d;
    logic [LENWIDTH-1:0]   len_q, len_d;
    logic                  ovf_q, ovf_d;

    // Completion stage between the accumulator and the output register.
    logic                  done_q, done_d;
    logic [ACCWIDTH-1:0]   done_sum_q, done_sum_d;
    logic                  done_ovf_q, done_ovf_d;

    logic                  out_valid_q, out_valid_d;
    logic [ACCWIDTH-1:0]   out_sum_q, out_sum_d;
    logic                  out_ovf_q, out_ovf_d;
    logic                  drop_q, drop_d;

    logic [LENWIDTH-1:0]   eff_len;
    logic [LENWIDTH-1:0]   cnt_inc;
    logic [ACCWIDTH-1:0]   prod_ext;
    logic [ACCWIDTH:0]     sum_ext;

    assign eff_len  = (i_len == '0) ? LENWIDTH'(1) : i_len;
    assign cnt_inc  = cnt_q + LENWIDTH'(1);
    assign prod_ext = ACCWIDTH'(i_product);
    assign sum_ext  = {1'b0, acc_q} + {1'b0, prod_ext};

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        done_sum_d = done_sum_q;
        done_ovf_d = done_ovf_q;

        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    len_d = eff_len;
                    if (eff_len == LENWIDTH'(1)) begin
                        // Single-product block: acc/cnt stay cleared.
                        done_d     = 1'b1;
                        done_sum_d = prod_ext;
                        done_ovf_d = 1'b0;
                    end else begin
                        acc_d   = prod_ext;
                        cnt_d   = LENWIDTH'(1);
                        ovf_d   = 1'b0;
                        state_d = StAccum;
                    end
                end
            end
            StAccum: begin
                if (i_valid) begin
                    if (cnt_inc == len_q) begin
                        done_d     = 1'b1;
                        done_sum_d = sum_ext[ACCWIDTH-1:0];
                        done_ovf_d = ovf_q | sum_ext[ACCWIDTH];
                        acc_d      = '0;
                        cnt_d      = '0;
                        ovf_d      = 1'b0;
                        state_d    = StIdle;
                    end else begin
                        acc_d = sum_ext[ACCWIDTH-1:0];
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | sum_ext[ACCWIDTH];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        drop_d      = drop_q;
        if (done_q) begin
            if (!out_valid_q || i_ready) begin
                out_valid_d = 1'b1;
                out_sum_d   = done_sum_q;
                out_ovf_d   = done_ovf_q;
            end else begin
                drop_d = 1'b1;
            end
        end else if (out_valid_q && i_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            done_sum_q  <= '0;
            done_ovf_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            done_sum_q  <= done_sum_d;
            done_ovf_q  <= done_ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
            drop_q      <= drop_d;
        end
    end

    assign o_valid    = out_valid_q;
    assign o_sum      = out_sum_q;
    assign o_overflow = out_ovf_q;
    assign o_drop     = drop_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed and randomized bench for product_accumulator (ACCWIDTH=32) against a
// transaction-level model that keeps each block's total as an unbounded integer.
module tb_product_accumulator;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 32;
    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_valid = 1'b0;
    logic [2*DW-1:0] i_product = '0;
    logic [LW-1:0] i_len = '0;
    logic          i_ready = 1'b0;
    logic          o_valid;
    logic [AW-1:0] o_sum;
    logic          o_overflow;
    logic          o_drop;

    int checks = 0;
    int errors = 0;

    product_accumulator #(
        .DATAWIDTH(DW),
        .ACCWIDTH (AW),
        .LENWIDTH (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_product (i_product),
        .i_len     (i_len),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_sum     (o_sum),
        .o_overflow(o_overflow),
        .o_drop    (o_drop)
    );

    always #5 clk = ~clk;

    // Reference model: open block with unbounded running total, a completion
    // in flight, and the output slot.
    bit              m_open;
    int unsigned     m_len;
    int unsigned     m_count;
    longint unsigned m_total;
    bit              m_pend;
    longint unsigned m_pend_sum;
    bit              m_pend_ovf;
    bit              m_out_valid;
    longint unsigned m_out_sum;
    bit              m_out_ovf;
    bit              m_drop;

    task automatic model_reset();
        m_open = 0; m_len = 0; m_count = 0; m_total = 0;
        m_pend = 0; m_pend_sum = 0; m_pend_ovf = 0;
        m_out_valid = 0; m_out_sum = 0; m_out_ovf = 0; m_drop = 0;
    endtask

    task automatic model_edge();
        bit              fin;
        longint unsigned fin_total;
        if (rst) begin
            model_reset();
            return;
        end
        fin = 0;
        fin_total = 0;
        if (i_valid) begin
            if (!m_open) begin
                m_len   = (i_len == 0) ? 1 : int'(i_len);
                m_total = longint'(i_product);
                m_count = 1;
                m_open  = 1;
            end else begin
                m_total += longint'(i_product);
                m_count++;
            end
            if (m_count == m_len) begin
                fin       = 1;
                fin_total = m_total;
                m_open    = 0;
            end
        end
        if (m_pend) begin
            if (!m_out_valid || i_ready) begin
                m_out_valid = 1;
                m_out_sum   = m_pend_sum;
                m_out_ovf   = m_pend_ovf;
            end else begin
                m_drop = 1;
            end
        end else if (m_out_valid && i_ready) begin
            m_out_valid = 0;
        end
        m_pend     = fin;
        m_pend_sum = fin_total & 64'hFFFF_FFFF;
        m_pend_ovf = (fin_total >> AW) != 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model, compare outputs.
    task automatic step(input bit r, input bit v, input logic [31:0] p, input int unsigned l,
                        input bit rdy);
        rst       = r;
        i_valid   = v;
        i_product = p;
        i_len     = LW'(l);
        i_ready   = rdy;
        @(posedge clk);
        model_edge();
        #1;
        chk("o_valid", {63'd0, o_valid}, {63'd0, m_out_valid});
        if (m_out_valid) begin
            chk("o_sum", {32'd0, o_sum}, m_out_sum);
            chk("o_overflow", {63'd0, o_overflow}, {63'd0, m_out_ovf});
        end
        chk("o_drop", {63'd0, o_drop}, {63'd0, m_drop});
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 32'd0, 0, rdy);
    endtask

    initial begin
        model_reset();
        step(1, 0, 32'd0, 0, 0);
        step(1, 1, 32'd55, 3, 1);
        chk("reset_valid", {63'd0, o_valid}, 64'd0);
        chk("reset_sum", {32'd0, o_sum}, 64'd0);
        chk("reset_drop", {63'd0, o_drop}, 64'd0);

        // Four consecutive products, single one-cycle result pulse.
        step(0, 1, 32'd10, 4, 1);
        step(0, 1, 32'd20, 0, 1);
        step(0, 1, 32'd30, 7, 1);
        step(0, 1, 32'd40, 1, 1);
        chk("len4_latency", {63'd0, o_valid}, 64'd0);
        idle(1);
        chk("len4_valid", {63'd0, o_valid}, 64'd1);
        chk("len4_sum", {32'd0, o_sum}, 64'd100);
        chk("len4_ovf", {63'd0, o_overflow}, 64'd0);
        idle(1);
        chk("len4_pulse", {63'd0, o_valid}, 64'd0);

        // Gapped block, then a zero-length request treated as one product.
        step(0, 1, 32'd5, 3, 1);
        idle(1); idle(1);
        step(0, 1, 32'd6, 9, 1);
        idle(1); idle(1);
        step(0, 1, 32'd7, 9, 1);
        idle(1);
        chk("gap_sum", {32'd0, o_sum}, 64'd18);
        step(0, 1, 32'd9, 0, 1);
        idle(1);
        chk("len0_valid", {63'd0, o_valid}, 64'd1);
        chk("len0_sum", {32'd0, o_sum}, 64'd9);

        // Wrap past 2^32.
        step(0, 1, 32'hFFFF_FFFF, 2, 1);
        step(0, 1, 32'h2, 2, 1);
        idle(1);
        chk("wrap_sum", {32'd0, o_sum}, 64'd1);
        chk("wrap_ovf", {63'd0, o_overflow}, 64'd1);
        idle(1); idle(1);

        // Back-to-back results with no consumer: second is dropped.
        step(0, 1, 32'd7, 1, 0);
        step(0, 1, 32'd8, 1, 0);
        idle(0);
        chk("drop_sum", {32'd0, o_sum}, 64'd7);
        chk("drop_flag", {63'd0, o_drop}, 64'd1);
        idle(1);
        chk("drop_drain", {63'd0, o_valid}, 64'd0);

        // Handoff coinciding with a new completion: no bubble.
        step(0, 1, 32'd11, 1, 0);
        idle(0);
        step(0, 1, 32'd12, 1, 0);
        idle(1);
        chk("nobubble_valid", {63'd0, o_valid}, 64'd1);
        chk("nobubble_sum", {32'd0, o_sum}, 64'd12);
        chk("drop_sticky", {63'd0, o_drop}, 64'd1);
        idle(1);

        // Abort a block with reset; next block carries no residue.
        step(0, 1, 32'd100, 4, 0);
        step(0, 1, 32'd200, 4, 0);
        step(1, 1, 32'd300, 4, 1);
        chk("abort_drop", {63'd0, o_drop}, 64'd0);
        step(0, 1, 32'd1, 2, 1);
        step(0, 1, 32'd2, 2, 1);
        idle(1);
        chk("abort_sum", {32'd0, o_sum}, 64'd3);

        for (int n = 0; n < 2000; n++) begin
            logic [31:0] p;
            p = ($urandom_range(0, 3) == 0) ? (32'hFFFF_0000 | $urandom) :
                32'($urandom_range(0, 1000));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, p,
                 $urandom_range(0, 5), $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 16: operand width of the upstream multiplier; product width is 2*DATAWIDTH.
REQ-002 SHALL have parameter ACCWIDTH, default 40: accumulator and result width, always at least 2*DATAWIDTH.
REQ-003 SHALL have parameter LENWIDTH, default 8: width of the block-length input.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port i_valid, input, 1: i_product valid this cycle; driven from the multiplier o_valid, so it cannot be back-pressured.
REQ-007 SHALL have port i_product, input, 2*DATAWIDTH: unsigned product, driven from the multiplier Z_final.
REQ-008 SHALL have port i_len, input, LENWIDTH: number of products per block; sampled only on the first product of a block.
REQ-009 SHALL have port o_valid, input-to-output role as output, 1: o_sum holds a completed block result.
REQ-010 SHALL have port i_ready, input, 1: downstream accepts the result when o_valid and i_ready are both 1.
REQ-011 SHALL have port o_sum, output, ACCWIDTH: completed block sum.
REQ-012 SHALL have port o_overflow, output, 1: carry out of ACCWIDTH occurred during the block in o_sum.
REQ-013 SHALL have port o_drop, output, 1: sticky flag; set when a completed result was lost.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (no block open) and ACCUM (block open).
REQ-015 SHALL, in IDLE with i_valid=1, take the effective length as L = i_len, or L = 1 when i_len = 0, register L, and load acc = i_product zero-extended with cnt = 1.
REQ-016 SHALL, in IDLE with i_valid=1 and L=1, complete the block in that same cycle and remain in IDLE; otherwise it SHALL go to ACCUM.
REQ-017 SHALL, in ACCUM with i_valid=1, compute acc + i_product, increment cnt, and OR the carry out of ACCWIDTH into the block overflow bit.
REQ-018 SHALL complete the block when the accepted product makes cnt equal to L, then return to IDLE with acc, cnt and the overflow bit cleared.
REQ-019 SHALL hold acc, cnt and state on cycles with i_valid=0, so input gaps of any length are allowed.
REQ-020 SHALL ignore i_len on every cycle except the first product of a block.
REQ-021 SHALL wrap the accumulator modulo 2^ACCWIDTH on overflow; only the overflow bit records the wrap.
REQ-022 SHALL give a completion latency of 1 cycle: last product accepted at edge t means o_valid=1 and o_sum valid after edge t+1.
REQ-023 SHALL use a one-entry output register.
REQ-024 SHALL, on completion when the output register is empty or is handed off in the same cycle (o_valid & i_ready), load o_sum and o_overflow and hold o_valid=1.
REQ-025 SHALL, on completion when the output register is full and i_ready=0, keep the old result, discard the new one, and set o_drop.
REQ-026 SHALL, on a handoff with no completion in the same cycle, clear o_valid on the next cycle.
REQ-027 SHALL hold o_sum and o_overflow stable while o_valid=1 and i_ready=0.
REQ-028 SHALL never stall accumulation, whatever the state of the output register.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, put the FSM in IDLE and clear acc, cnt, L, o_valid, o_sum, o_overflow and o_drop.
REQ-030 SHALL discard an open block and an unaccepted result when rst is asserted mid-operation.
REQ-031 SHALL give rst priority over i_valid and i_ready in the same cycle.
REQ-032 SHALL clear o_drop only by rst.

Verification
REQ-033 SHALL cover: i_len=4, products 10, 20, 30, 40 on consecutive cycles, i_ready=1 -> o_valid pulses once, 1 cycle after the last product, with o_sum=100 and o_overflow=0.
REQ-034 SHALL cover: i_len=3, products 5, 6, 7 with 2-cycle gaps, then i_len=0 with product 9 -> results 18, then 9 as a single-product block.
REQ-035 SHALL cover: ACCWIDTH=32, i_len=2, products 0xFFFFFFFF and 0x2 -> o_sum=0x1, o_overflow=1.
REQ-036 SHALL cover: i_ready=0, two back-to-back blocks of length 1 with products 7 then 8 -> o_sum stays 7, o_drop=1; after i_ready=1 one cycle, o_valid=0.
REQ-037 SHALL cover: i_ready=1 during a completion while o_valid=1 -> old result handed off, new result loaded, o_valid stays 1 with no bubble.
REQ-038 SHALL cover: rst after 2 of 4 products, then a new block with i_len=2 and products 1, 2 -> o_sum=3 with no residue from the aborted block.
